// File: rtl/secure_tdm_mux_pkg.sv
// Shared definitions for the domain-aware TDM mux:
// FSM encodings and internal counter widths.
package secure_tdm_mux_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_SCRUB = 2'd3;

    localparam int BEAT_W  = 8;
    localparam int SCRUB_W = 4;

endpackage

// File: rtl/secure_tdm_mux_rr.sv
// Combinational round-robin pick: search starts at last+1 and wraps,
// so the previous winner is considered last.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [$clog2(NCH)-1:0] winner,
    output logic                   found
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = IW'((int'(last) + k) % NCH);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/secure_tdm_mux.sv
// N-channel valid/ready TDM mux with per-channel security domains;
// a domain change drains the output and inserts zeroed scrub cycles.
module secure_tdm_mux
    import secure_tdm_mux_pkg::*;
#(
    parameter int                   WIDTH     = 8,
    parameter int                   NCH       = 4,
    parameter int                   DOM_W     = 1,
    parameter logic [NCH*DOM_W-1:0] CH_DOM    = '0,
    parameter int                   SLOT      = 4,
    parameter int                   SCRUB_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [DOM_W-1:0]       out_dom,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic                   scrubbing
);

    localparam int IW = $clog2(NCH);

    logic [1:0]         state;
    logic [IW-1:0]      last, cur, nxt;
    logic [IW-1:0]      arb_last, win;
    logic [DOM_W-1:0]   cur_dom;
    logic               dom_vld, found;
    logic               grant_rdy, xfer, rel, pick, dom_switch;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [SCRUB_W-1:0] scrub_cnt;

    function automatic logic [DOM_W-1:0] dom_of(input logic [IW-1:0] ch);
        return CH_DOM[int'(ch)*DOM_W +: DOM_W];
    endfunction

    // On release the current channel is treated as the last winner.
    assign arb_last = (state == S_GRANT) ? cur : last;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req    (in_valid),
        .last   (arb_last),
        .winner (win),
        .found  (found)
    );

    always_comb begin
        grant_rdy  = (state == S_GRANT) && (!out_valid || out_ready);
        in_ready   = grant_rdy ? (NCH'(1) << cur) : '0;
        xfer       = grant_rdy && in_valid[cur];
        rel        = (state == S_GRANT)
                     && (!in_valid[cur]
                         || (xfer && beat_cnt == BEAT_W'(SLOT - 1)));
        pick       = found && ((state == S_IDLE) || rel);
        dom_switch = dom_vld && (dom_of(win) != cur_dom);
    end

    assign scrubbing = (state == S_SCRUB);
    assign out_dom   = scrubbing ? dom_of(nxt) : cur_dom;
    assign out_ch    = scrubbing ? nxt : cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last      <= IW'(NCH - 1);
            cur       <= '0;
            nxt       <= '0;
            cur_dom   <= '0;
            dom_vld   <= 1'b0;
            beat_cnt  <= '0;
            scrub_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(cur)*WIDTH +: WIDTH];
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end

            unique case (state)
                S_GRANT: begin
                    if (rel) begin
                        last     <= cur;
                        beat_cnt <= '0;
                        if (!found) state <= S_IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state     <= S_SCRUB;
                        scrub_cnt <= '0;
                    end
                end
                S_SCRUB: begin
                    if (scrub_cnt == SCRUB_W'(SCRUB_CYC - 1)) begin
                        state   <= S_GRANT;
                        cur     <= nxt;
                        cur_dom <= dom_of(nxt);
                    end else begin
                        scrub_cnt <= scrub_cnt + 4'd1;
                    end
                end
                default: ;
            endcase

            // Arbitration result from IDLE or a same-cycle GRANT release.
            if (pick) begin
                nxt <= win;
                if (dom_switch) begin
                    state <= S_DRAIN;
                end else begin
                    state   <= S_GRANT;
                    cur     <= win;
                    cur_dom <= dom_of(win);
                    dom_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_secure_tdm_mux.sv
// Scoreboard bench for secure_tdm_mux: directed channel bursts with
// hand-ordered expected beats plus per-cycle trace checks.
module tb_secure_tdm_mux;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int DOM_W = 1;
    localparam logic [NCH*DOM_W-1:0] CH_DOM = 4'b1100;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       in_valid, in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid, out_ready, scrubbing;
    logic [WIDTH-1:0]     out_data;
    logic [DOM_W-1:0]     out_dom;
    logic [1:0]           out_ch;

    always #5 clk = ~clk;

    secure_tdm_mux #(
        .WIDTH(WIDTH), .NCH(NCH), .DOM_W(DOM_W), .CH_DOM(CH_DOM),
        .SLOT(4), .SCRUB_CYC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dom(out_dom), .out_ch(out_ch), .scrubbing(scrubbing)
    );

    typedef struct packed {
        logic [DOM_W-1:0] dom;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t          exp_q[$];
    beat_t          mon_e;
    int             n_checks = 0;
    int             n_fail = 0;
    int             rem[NCH];
    logic [5:0]     seq[NCH];
    logic [NCH-1:0] hs;

    logic           rec;
    int             rec_n;
    logic           tv[64], ts[64], tor[64];
    logic [DOM_W-1:0] tdom[64];
    logic [WIDTH-1:0] tdat[64];
    logic [NCH-1:0] tir[64], tiv[64];
    logic [1:0]     tch[64];

    function automatic logic [WIDTH-1:0] dval(input int ch, input int s);
        return WIDTH'(ch * 64 + s);
    endfunction

    function automatic logic [DOM_W-1:0] tb_dom(input int ch);
        return (ch >= 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            in_valid[i] = rem[i] > 0;
            in_data[i*WIDTH +: WIDTH] = dval(i, int'(seq[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int ch, input int n);
        rem[ch] = n;
        drive();
    endtask

    task automatic expect_beats(input int ch, input int s0, input int n);
        for (int j = 0; j < n; j++)
            exp_q.push_back('{dom: tb_dom(ch), data: dval(ch, s0 + j)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            rem[i] = 0;
            seq[i] = '0;
        end
        drive();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_rec();
        rec_n = 0;
        rec = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 300) begin
            tick();
            b++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        repeat (4) tick();
        rec = 1'b0;
    endtask

    function automatic int n_scrub();
        int c = 0;
        for (int k = 0; k < rec_n; k++) if (ts[k]) c++;
        return c;
    endfunction

    function automatic int f_scrub();
        for (int k = 0; k < rec_n; k++) if (ts[k]) return k;
        return -1;
    endfunction

    function automatic int l_scrub();
        for (int k = rec_n - 1; k >= 0; k--) if (ts[k]) return k;
        return -1;
    endfunction

    function automatic int n_valid();
        int c = 0;
        for (int k = 0; k < rec_n; k++) if (tv[k]) c++;
        return c;
    endfunction

    function automatic int f_valid();
        for (int k = 0; k < rec_n; k++) if (tv[k]) return k;
        return -1;
    endfunction

    function automatic int l_valid();
        for (int k = rec_n - 1; k >= 0; k--) if (tv[k]) return k;
        return -1;
    endfunction

    function automatic int nv_after(input int j);
        for (int k = j + 1; k < rec_n; k++) if (tv[k]) return k;
        return -1;
    endfunction

    function automatic int last_dom0_valid();
        for (int k = rec_n - 1; k >= 0; k--)
            if (tv[k] && tdom[k] == 1'b0) return k;
        return -1;
    endfunction

    // Source driver: handshakes sampled mid-cycle, advanced after the edge.
    initial begin
        forever begin
            @(negedge clk);
            hs = in_valid & in_ready & {NCH{!rst}};
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++)
                if (hs[i] && rem[i] > 0) begin
                    rem[i]--;
                    seq[i]++;
                end
            drive();
        end
    end

    // Monitor: scoreboard pop on every accepted output beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!out_valid) chk("zero_when_idle", out_data, 0);
                chk("onehot_ready", $countones(in_ready) <= 1, 1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("beat_data", out_data, mon_e.data);
                        chk("beat_dom", out_dom, mon_e.dom);
                    end
                end
                if (rec && rec_n < 64) begin
                    tv[rec_n]   = out_valid;
                    ts[rec_n]   = scrubbing;
                    tor[rec_n]  = out_ready;
                    tdom[rec_n] = out_dom;
                    tdat[rec_n] = out_data;
                    tir[rec_n]  = in_ready;
                    tiv[rec_n]  = in_valid;
                    tch[rec_n]  = out_ch;
                    rec_n++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, stall_n, ls, a;
        rst = 1'b1;
        out_ready = 1'b1;
        rec = 1'b0;
        rec_n = 0;
        for (int i = 0; i < NCH; i++) begin
            rem[i] = 0;
            seq[i] = '0;
        end
        drive();
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_dom", out_dom, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_scrubbing", scrubbing, 0);
        tick();
        rst = 1'b0;

        // Single channel, 10 beats across slot boundaries.
        start_rec();
        expect_beats(0, 0, 10);
        load(0, 10);
        wait_empty("t1");
        chk("t1_arb_idle", tir[0], 4'b0000);
        chk("t1_arb_latency", tir[1], 4'b0001);
        d = 0;
        for (int k = 1; k < rec_n; k++) if (tiv[k][0] && !tir[k][0]) d++;
        chk("t1_ready_drop", d, 0);
        chk("t1_first_out", f_valid(), 2);
        chk("t1_valid_cnt", n_valid(), 10);
        chk("t1_valid_span", l_valid() - f_valid(), 9);
        chk("t1_no_scrub", n_scrub(), 0);

        // Two same-domain channels alternate with no bubbles.
        do_reset();
        start_rec();
        expect_beats(0, 0, 4);
        expect_beats(1, 0, 4);
        expect_beats(0, 4, 4);
        expect_beats(1, 4, 4);
        load(0, 8);
        load(1, 8);
        wait_empty("t2");
        chk("t2_valid_cnt", n_valid(), 16);
        chk("t2_valid_span", l_valid() - f_valid(), 15);
        chk("t2_no_scrub", n_scrub(), 0);
        d = 0;
        for (int k = 0; k < rec_n; k++) if (tdom[k] != 1'b0) d++;
        chk("t2_dom_zero", d, 0);

        // Domain switch 0 -> 1 with free-flowing output.
        do_reset();
        start_rec();
        expect_beats(1, 0, 4);
        expect_beats(2, 0, 4);
        load(1, 4);
        load(2, 4);
        wait_empty("t3");
        chk("t3_scrub_cnt", n_scrub(), 2);
        chk("t3_scrub_start", f_scrub(), 6);
        chk("t3_scrub_span", l_scrub() - f_scrub(), 1);
        d = 0;
        for (int k = 0; k < rec_n; k++)
            if (ts[k] && (tv[k] || tdat[k] != 0 || tdom[k] != 1'b1
                          || tch[k] != 2'd2)) d++;
        chk("t3_scrub_clean", d, 0);
        chk("t3_scrub_after_last", f_scrub() - last_dom0_valid(), 1);
        chk("t3_resume_gap", nv_after(l_scrub()) - l_scrub(), 2);

        // Domain switch while the output is stalled for 5 cycles.
        do_reset();
        start_rec();
        expect_beats(1, 0, 4);
        expect_beats(2, 0, 4);
        load(1, 4);
        load(2, 4);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(out_valid && out_data == dval(1, 2)) && b < 50);
        chk("t4_sync", b < 50, 1);
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_empty("t4");
        stall_n = 0;
        ls = -1;
        d = 0;
        for (int k = 0; k < rec_n; k++)
            if (!tor[k]) begin
                stall_n++;
                ls = k;
                if (!tv[k] || tdat[k] != dval(1, 3) || tir[k] != 0 || ts[k])
                    d++;
            end
        chk("t4_stall_cycles", stall_n, 5);
        chk("t4_stall_hold", d, 0);
        a = last_dom0_valid();
        chk("t4_accept_after_stall", a - ls, 1);
        chk("t4_scrub_after_accept", f_scrub() - a, 1);
        chk("t4_scrub_cnt", n_scrub(), 2);
        chk("t4_ch2_after_scrub", nv_after(l_scrub()) - l_scrub(), 2);

        // Reset in the middle of a domain-1 grant.
        do_reset();
        expect_beats(3, 0, 8);
        load(3, 8);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!out_valid && b < 50);
        chk("t5_sync", b < 50, 1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) rem[i] = 0;
        drive();
        exp_q.delete();
        tick();
        @(negedge clk);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_ready", in_ready, 0);
        chk("t5_rst_scrub", scrubbing, 0);
        tick();
        rst = 1'b0;
        start_rec();
        expect_beats(0, 0, 3);
        load(0, 3);
        wait_empty("t5");
        chk("t5_grant_ch0", tir[1], 4'b0001);
        chk("t5_no_scrub", n_scrub(), 0);

        // Early drop of in_valid, then regrant with a fresh slot.
        do_reset();
        start_rec();
        expect_beats(3, 0, 2);
        load(3, 2);
        wait_empty("t6a");
        d = 0;
        for (int k = 0; k < rec_n; k++) if (tir[k][3]) d++;
        chk("t6_ready_cycles", d, 3);
        start_rec();
        expect_beats(3, 2, 4);
        expect_beats(2, 0, 1);
        load(3, 4);
        tick();
        load(2, 1);
        wait_empty("t6b");
        chk("t6_no_scrub", n_scrub(), 0);
        chk("t6_valid_cnt", n_valid(), 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
